// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: request/ready handshake between the control unit and the unified memory
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;
  modport master(output mem_req, mem_we, adr_src, input mem_ready);
  modport slave(input mem_req, mem_we, adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer with bus-timeout/illegal-opcode trapping and retire counter
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       fun3,
  input  logic             fun7b5,
  input  logic             zero_f,
  multicycle_ctrl_if.master mem,
  output logic             pc_write,
  output logic             ir_write,
  output logic             regwrite,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic [3:0]       alu_ctrl,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
    JAL = 4'd10, JALR1 = 4'd11, JALR2 = 4'd12, UTYPE = 4'd13, TRAP = 4'd15
  } state_t;
  localparam int WW = $clog2(TIMEOUT + 2);
  state_t st, st_n;
  logic [WW-1:0] wcnt;
  logic [1:0] cause_n;
  logic [3:0] alu_r;
  logic retire, req, we, pcw, irw, rw, adr, tmo;
  always_comb
    case (fun3)
      3'b000: alu_r = fun7b5 ? 4'b0001 : 4'b0000;
      3'b001: alu_r = 4'b0111;
      3'b010: alu_r = 4'b0101;
      3'b011: alu_r = 4'b0110;
      3'b100: alu_r = 4'b0100;
      3'b101: alu_r = fun7b5 ? 4'b1001 : 4'b1000;
      3'b110: alu_r = 4'b0011;
      default: alu_r = 4'b0010;
    endcase
  always_comb begin
    st_n = st;
    cause_n = trap_cause;
    retire = 1'b0;
    req = 1'b0;
    we = 1'b0;
    pcw = 1'b0;
    irw = 1'b0;
    rw = 1'b0;
    adr = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    result_src = 2'b00;
    imm_src = 3'b000;
    alu_ctrl = 4'b0000;
    case (st)
      FETCH: begin
        req = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        irw = mem.mem_ready;
        pcw = mem.mem_ready;
        st_n = mem.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src = 3'b010;
        case (opcode)
          7'b0000011, 7'b0100011: st_n = MEMADR;
          7'b0110011: st_n = EXECR;
          7'b0010011: st_n = EXECI;
          7'b1100011: st_n = BRANCH;
          7'b1101111: st_n = JAL;
          7'b1100111: st_n = JALR1;
          7'b0110111, 7'b0010111: st_n = UTYPE;
          default: begin
            st_n = TRAP;
            cause_n = 2'b01;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src = opcode[5] ? 3'b001 : 3'b000;
        st_n = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        req = 1'b1;
        adr = 1'b1;
        st_n = mem.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        rw = 1'b1;
        retire = 1'b1;
        st_n = FETCH;
      end
      MEMWRITE: begin
        req = 1'b1;
        we = 1'b1;
        adr = 1'b1;
        retire = mem.mem_ready;
        st_n = mem.mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl = alu_r;
        st_n = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl = fun3 == 3'b000 ? 4'b0000 : alu_r;
        st_n = ALUWB;
      end
      ALUWB: begin
        rw = 1'b1;
        retire = 1'b1;
        st_n = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl = fun3[2] ? (fun3[1] ? 4'b0110 : 4'b0101) : (fun3[1] ? 4'b0000 : 4'b0001);
        // Inverting on fun3[2]^fun3[0] maps bne/blt/bltu to "taken when non-zero"
        if (fun3[2:1] == 2'b01) begin
          st_n = TRAP;
          cause_n = 2'b01;
        end else begin
          pcw = zero_f ^ fun3[2] ^ fun3[0];
          retire = 1'b1;
          st_n = FETCH;
        end
      end
      JAL, JALR2: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcw = 1'b1;
        st_n = ALUWB;
      end
      JALR1: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        st_n = JALR2;
      end
      UTYPE: begin
        alu_src_a = opcode[5] ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        imm_src = 3'b100;
        st_n = ALUWB;
      end
      TRAP: st_n = TRAP;
      default: st_n = FETCH;
    endcase
    // A ready arriving on the last allowed wait cycle still completes the access
    tmo = TIMEOUT != 0 && req && !mem.mem_ready && int'(wcnt) == TIMEOUT - 1;
    if (tmo) begin
      st_n = TRAP;
      cause_n = 2'b10;
      retire = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= FETCH;
      wcnt <= '0;
      instret <= '0;
      trap_cause <= 2'b00;
    end else begin
      st <= st_n;
      trap_cause <= cause_n;
      wcnt <= st_n != st ? '0 : (req && !mem.mem_ready) ? wcnt + WW'(1) : wcnt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  assign mem.mem_req = req & rst;
  assign mem.mem_we = we & rst;
  assign mem.adr_src = adr;
  assign pc_write = pcw & rst;
  assign ir_write = irw & rst;
  assign regwrite = rw & rst;
  assign trap = st == TRAP;
  assign state = st;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scenarios plus randomized instruction streams against a path-table model
module tb_multicycle_ctrl;
  logic clk = 0, rst = 1;
  logic [6:0] opcode = 0;
  logic [2:0] fun3 = 0;
  logic fun7b5 = 0, zero_f = 0;
  logic pc_write, ir_write, regwrite, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src, trap_cause;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl, state, instret;
  int checks = 0, errors = 0, mret = 0;
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23, OP_BR = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6f, OP_JALR = 7'h67, OP_LUI = 7'h37, OP_AUI = 7'h17;
  multicycle_ctrl_if mif();
  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .fun3(fun3), .fun7b5(fun7b5), .zero_f(zero_f),
    .mem(mif), .pc_write(pc_write), .ir_write(ir_write), .regwrite(regwrite),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .trap(trap), .trap_cause(trap_cause), .instret(instret), .state(state)
  );
  always #5 clk = ~clk;

  function automatic logic br_taken(input logic [2:0] f, input logic z);
    case (f)
      3'b000, 3'b101, 3'b111: return z;
      default: return !z;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input int s, input logic [2:0] f, input logic b);
    if (s == 9) return (f < 3'd4) ? 4'd1 : (f < 3'd6) ? 4'd5 : 4'd6;
    case (f)
      3'd0: return (s == 6 && b) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return b ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  task automatic step(input logic [6:0] o, input logic [2:0] f, input logic b, input logic z, input logic r);
    @(negedge clk);
    opcode = o; fun3 = f; fun7b5 = b; zero_f = z; mif.mem_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; mif.mem_ready = 0;
    @(posedge clk);
    #2 rst = 1;
    mret = 0;
  endtask

  task automatic test_reset();
    #2 rst = 0; mif.mem_ready = 1; opcode = OP_I;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
    checks++; if ({trap, trap_cause} !== 3'b000) begin errors++; $display("FAIL reset_trap: got %b want 000", {trap, trap_cause}); end
    checks++; if ({pc_write, ir_write, regwrite, mif.mem_req, mif.mem_we} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {pc_write, ir_write, regwrite, mif.mem_req, mif.mem_we}); end
    checks++; if ({alu_src_a, alu_src_b, result_src, alu_ctrl, mif.adr_src} !== 11'b00_10_10_0000_0) begin errors++; $display("FAIL reset_decode: got %b want 00101000000", {alu_src_a, alu_src_b, result_src, alu_ctrl, mif.adr_src}); end
  endtask

  task automatic test_addi();
    int exp_st[5];
    exp_st = '{0, 1, 7, 8, 0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
      checks++; if (state !== 4'(exp_st[c])) begin errors++; $display("FAIL addi_state: cyc %0d got %0d want %0d", c, state, exp_st[c]); end
      checks++; if (regwrite !== (c == 3)) begin errors++; $display("FAIL addi_regwrite: cyc %0d got %b want %b", c, regwrite, c == 3); end
    end
    checks++; if (instret !== 4'd1) begin errors++; $display("FAIL addi_instret: got %0d want 1", instret); end
  endtask

  task automatic test_load_wait();
    int exp_st[9];
    logic rdy[9];
    exp_st = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    rdy = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(OP_LD, 3'b010, 1'b0, 1'b0, rdy[c]);
      checks++; if (state !== 4'(exp_st[c])) begin errors++; $display("FAIL lw_state: cyc %0d got %0d want %0d", c, state, exp_st[c]); end
      if (c >= 3 && c <= 6) begin
        checks++; if ({mif.mem_req, mif.adr_src, mif.mem_we} !== 3'b110) begin errors++; $display("FAIL lw_bus: cyc %0d got %b want 110", c, {mif.mem_req, mif.adr_src, mif.mem_we}); end
      end
      checks++; if (regwrite !== (c == 7)) begin errors++; $display("FAIL lw_regwrite: cyc %0d got %b want %b", c, regwrite, c == 7); end
      if (c == 7) begin
        checks++; if (result_src !== 2'b01) begin errors++; $display("FAIL lw_result_src: got %b want 01", result_src); end
      end
    end
    checks++; if (instret !== 4'd1) begin errors++; $display("FAIL lw_instret: got %0d want 1", instret); end
  endtask

  task automatic test_branch();
    logic [2:0] tf[5];
    logic tz[5], tp[5];
    logic [3:0] ta[5];
    tf = '{3'b001, 3'b001, 3'b100, 3'b111, 3'b000};
    tz = '{0, 1, 0, 1, 0};
    tp = '{1, 0, 1, 1, 0};
    ta = '{4'b0001, 4'b0001, 4'b0101, 4'b0110, 4'b0001};
    for (int t = 0; t < 5; t++) begin
      do_reset();
      step(OP_BR, tf[t], 1'b0, tz[t], 1'b1);
      step(OP_BR, tf[t], 1'b0, tz[t], 1'b0);
      step(OP_BR, tf[t], 1'b0, tz[t], 1'b0);
      checks++; if (state !== 4'd9) begin errors++; $display("FAIL br_state: row %0d got %0d want 9", t, state); end
      checks++; if (alu_ctrl !== ta[t]) begin errors++; $display("FAIL br_alu: row %0d got %b want %b", t, alu_ctrl, ta[t]); end
      checks++; if (pc_write !== tp[t]) begin errors++; $display("FAIL br_pc_write: row %0d got %b want %b", t, pc_write, tp[t]); end
      step(OP_BR, tf[t], 1'b0, tz[t], 1'b0);
      checks++; if ({state, instret} !== 8'h01) begin errors++; $display("FAIL br_retire: row %0d got state %0d instret %0d want 0/1", t, state, instret); end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    step(7'h7f, 3'b000, 1'b0, 1'b0, 1'b1);
    step(7'h7f, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL ill_decode: got %0d want 1", state); end
    step(7'h7f, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if ({state, trap, trap_cause} !== 7'b1111_1_01) begin errors++; $display("FAIL ill_trap: got state %0d trap %b cause %b want 15/1/01", state, trap, trap_cause); end
    for (int c = 0; c < 20; c++) begin
      step(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++; if ({state, pc_write, ir_write, regwrite, mif.mem_req, mif.mem_we, trap} !== {4'hf, 5'b0, 1'b1}) begin errors++; $display("FAIL ill_hold: cyc %0d got state %0d strobes %b trap %b", c, state, {pc_write, ir_write, regwrite, mif.mem_req, mif.mem_we}, trap); end
    end
    rst = 0;
    #1;
    checks++; if ({state, trap, trap_cause} !== 7'b0) begin errors++; $display("FAIL ill_reset: got state %0d trap %b cause %b want 0/0/00", state, trap, trap_cause); end
    @(posedge clk);
    #2 rst = 1;
    mret = 0;
    step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL ill_release: got %0d want 0", state); end
    do_reset();
    step(OP_BR, 3'b010, 1'b0, 1'b1, 1'b1);
    step(OP_BR, 3'b010, 1'b0, 1'b1, 1'b0);
    step(OP_BR, 3'b010, 1'b0, 1'b1, 1'b0);
    checks++; if ({state, pc_write} !== 5'b1001_0) begin errors++; $display("FAIL br_undef: got state %0d pc_write %b want 9/0", state, pc_write); end
    step(OP_BR, 3'b010, 1'b0, 1'b1, 1'b0);
    checks++; if ({state, trap_cause, instret} !== 10'b1111_01_0000) begin errors++; $display("FAIL br_undef_trap: got state %0d cause %b instret %0d want 15/01/0", state, trap_cause, instret); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(OP_I, 3'b000, 1'b0, 1'b0, 1'b0);
      checks++; if ({state, mif.mem_req} !== 5'b0000_1) begin errors++; $display("FAIL to_wait: cyc %0d got state %0d req %b want 0/1", c, state, mif.mem_req); end
    end
    step(OP_I, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if ({state, trap_cause, mif.mem_req} !== 7'b1111_10_0) begin errors++; $display("FAIL to_fetch: got state %0d cause %b req %b want 15/10/0", state, trap_cause, mif.mem_req); end
    do_reset();
    for (int c = 0; c < 4; c++) step(OP_I, 3'b000, 1'b0, 1'b0, c == 3);
    step(OP_I, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if ({state, trap} !== 5'b0001_0) begin errors++; $display("FAIL to_ready_wins: got state %0d trap %b want 1/0", state, trap); end
    do_reset();
    step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b1);
    step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
    step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
      checks++; if ({state, mif.mem_req, mif.mem_we, mif.adr_src} !== 7'b0101_111) begin errors++; $display("FAIL to_sw_wait: cyc %0d got state %0d bus %b want 5/111", c, state, {mif.mem_req, mif.mem_we, mif.adr_src}); end
    end
    step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
    checks++; if ({state, trap_cause, instret} !== 10'b1111_10_0000) begin errors++; $display("FAIL to_sw: got state %0d cause %b instret %0d want 15/10/0", state, trap_cause, instret); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
      step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
      checks++; if (instret !== 4'(i % 16)) begin errors++; $display("FAIL wrap_count: instr %0d got %0d want %0d", i, instret, i % 16); end
      step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
      step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
    end
    step(OP_I, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (instret !== 4'd1) begin errors++; $display("FAIL wrap_final: got %0d want 1", instret); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    repeat (4) step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
    step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b1);
    checks++; if (instret !== 4'd1) begin errors++; $display("FAIL rmw_pre: got %0d want 1", instret); end
    step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
    step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
    step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
    checks++; if ({state, mif.mem_we} !== 5'b0101_1) begin errors++; $display("FAIL rmw_write: got state %0d we %b want 5/1", state, mif.mem_we); end
    rst = 0;
    #1;
    checks++; if ({mif.mem_we, mif.mem_req, state, instret} !== 10'b0) begin errors++; $display("FAIL rmw_abort: got we %b req %b state %0d instret %0d want all 0", mif.mem_we, mif.mem_req, state, instret); end
    @(posedge clk);
    #2 rst = 1;
    mret = 0;
    step(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
    checks++; if ({state, instret} !== 8'h00) begin errors++; $display("FAIL rmw_release: got state %0d instret %0d want 0/0", state, instret); end
  endtask

  task automatic test_random();
    logic [6:0] ops[9];
    int brf[6];
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUI};
    brf = '{0, 1, 4, 5, 6, 7};
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int cls, d, s;
      logic [2:0] f3;
      logic f7, z, r;
      int mid[$], sq[$];
      logic rq[$];
      sq.delete(); rq.delete();
      cls = $urandom_range(0, 8);
      f3 = (cls == 4) ? 3'(brf[$urandom_range(0, 5)]) : 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      case (cls)
        0: mid = {6, 8};
        1: mid = {7, 8};
        2: mid = {2, 3, 4};
        3: mid = {2, 5};
        4: mid = {9};
        5: mid = {10, 8};
        6: mid = {11, 12, 8};
        default: mid = {13, 8};
      endcase
      d = $urandom_range(0, 3);
      repeat (d) begin sq.push_back(0); rq.push_back(1'b0); end
      sq.push_back(0); rq.push_back(1'b1);
      sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
      foreach (mid[k]) begin
        d = (mid[k] == 3 || mid[k] == 5) ? int'($urandom_range(0, 3)) : 0;
        repeat (d) begin sq.push_back(mid[k]); rq.push_back(1'b0); end
        sq.push_back(mid[k]);
        rq.push_back((mid[k] == 3 || mid[k] == 5) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      foreach (sq[i]) begin
        s = sq[i];
        r = rq[i];
        step(ops[cls], f3, f7, z, r);
        checks++; if ({state, trap} !== {4'(s), 1'b0}) begin errors++; $display("FAIL rand_state: instr %0d cyc %0d got %0d/%b want %0d/0", n, i, state, trap, s); end
        checks++; if ({mif.mem_req, mif.mem_we, mif.adr_src} !== {s == 0 || s == 3 || s == 5, s == 5, s == 3 || s == 5}) begin errors++; $display("FAIL rand_bus: instr %0d state %0d got %b", n, s, {mif.mem_req, mif.mem_we, mif.adr_src}); end
        checks++; if ({regwrite, ir_write, pc_write} !== {s == 4 || s == 8, s == 0 && r, (s == 0 && r) || (s == 9 && br_taken(f3, z)) || s == 10 || s == 12}) begin errors++; $display("FAIL rand_strobes: instr %0d state %0d f3 %b z %b got rw/ir/pc %b", n, s, f3, z, {regwrite, ir_write, pc_write}); end
        checks++; if (instret !== 4'(mret)) begin errors++; $display("FAIL rand_instret: instr %0d got %0d want %0d", n, instret, mret); end
        if (s == 6 || s == 7 || s == 9) begin
          checks++; if (alu_ctrl !== ref_alu(s, f3, f7)) begin errors++; $display("FAIL rand_alu: state %0d f3 %b f7 %b got %b want %b", s, f3, f7, alu_ctrl, ref_alu(s, f3, f7)); end
        end
        if (s == 4 || s == 8 || s == 9 || (s == 5 && r)) mret = (mret + 1) % 16;
      end
    end
  endtask

  initial begin
    mif.mem_ready = 0;
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_wrap();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle RV32I control unit: the successor to the single-cycle `control`/`alu_con` pair. It sequences one instruction over several cycles through a shared ALU and a unified instruction/data memory that signals completion with a ready handshake. It also adds bus-timeout and illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register fields and the multi-cycle datapath.

## Interface
- `TIMEOUT`, 16: maximum wait cycles per memory access; 0 disables the timeout.
- `CNT_W`, 32: width of `instret`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `opcode`  in  7  IR[6:0].
- `fun3`  in  3  IR[14:12].
- `fun7b5`  in  1  IR[30].
- `zero_f`  in  1  ALU zero flag, combinational from this cycle's ALU operation.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `pc_write`, `ir_write`, `regwrite`, `mem_req`, `mem_we`  out  1 each  strobes.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `result_src`  out  2  result select: 00 = ALUOut, 01 = Data register, 10 = ALU result.
- `imm_src`  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `alu_ctrl`  out  4  ALU operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
- `trap`  out  1  core halted.
- `trap_cause`  out  2  00 = none, 01 = illegal opcode, 10 = bus timeout.
- `instret`  out  CNT_W  count of retired instructions.
- `state`  out  4  current state, for debug.

## Operation
State encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5.
- EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, JALR1 = 11, JALR2 = 12, UTYPE = 13, TRAP = 15.

All outputs are decoded combinationally from `state`, the instruction fields and `mem_ready`. Any signal not listed for a state is 0.

- FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_ctrl`=ADD, `result_src`=10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - When `mem_ready`=1, go to DECODE; otherwise stay.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `imm_src`=B, `alu_ctrl`=ADD (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH.
  - 1101111 -> JAL; 1100111 -> JALR1; 0110111 or 0010111 -> UTYPE.
  - any other opcode -> TRAP with cause 01.
- MEMADR: A=rs1, B=imm, ADD; `imm_src`=S for stores, I for loads. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. On `mem_ready` go to MEMWB.
- MEMWB: `result_src`=01, `regwrite`=1; retires; go to FETCH.
- MEMWRITE: `mem_req`=`mem_we`=1, `adr_src`=1. On `mem_ready`, retire and go to FETCH.
- EXECR: A=rs1, B=rs2. `alu_ctrl` from `fun3`/`fun7b5`: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND. Go to ALUWB.
- EXECI: A=rs1, B=imm, `imm_src`=I. Same decode as EXECR, except SUB is never selected for `fun3`=000. `fun7b5` selects SRA only when `fun3`=101. Go to ALUWB.
- ALUWB: `result_src`=00, `regwrite`=1; retires; go to FETCH.
- BRANCH: A=rs1, B=rs2, `result_src`=00.
  - `fun3` 000/001 use SUB; 100/101 use SLT; 110/111 use SLTU.
  - `pc_write` is 1 when: beq and `zero_f`; bne and !`zero_f`; blt/bltu and !`zero_f`; bge/bgeu and `zero_f`.
  - Undefined `fun3` (010/011) -> TRAP with cause 01.
  - Otherwise retire and go to FETCH.
- JAL: A=OldPC, B=4, `result_src`=00, `pc_write`=1 (PC = the target latched in DECODE). Go to ALUWB.
- JALR1: A=rs1, B=imm, `imm_src`=I, ADD. Go to JALR2.
- JALR2: A=OldPC, B=4, `result_src`=00, `pc_write`=1. Go to ALUWB.
- UTYPE: A=11 for LUI or 01 for AUIPC, B=imm, `imm_src`=U, ADD. Go to ALUWB.
- TRAP: all strobes 0; `trap`=1; `trap_cause` holds its value. Only reset leaves TRAP.
- Wait counter: clears on entry to FETCH, MEMREAD and MEMWRITE, and increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When it reaches `TIMEOUT` with `TIMEOUT`≠0, the next state is TRAP with cause 10.
  - `mem_ready` arriving in the same cycle as the timeout wins.
- `instret` increments by 1 on each retirement and wraps modulo 2^CNT_W.

## Timing
- Reset asserted, asynchronously: `state`=FETCH, `instret`=0, `trap`=0, `trap_cause`=00, wait counter = 0.
  - All strobes are forced to 0 while `rst`=0.
  - Non-strobe outputs show FETCH decode.
  - Reset asserted mid-access abandons the access; no write and no retirement.
- Latency with `mem_ready` in the first request cycle:
  - R/I/U-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles.
  - JALR: 5 cycles.
  - Each wait cycle adds 1.
- `mem_req`, `adr_src` and `mem_we` are stable from the first request cycle until the cycle `mem_ready`=1.

## Test plan
- Reset release, then `addi` (0x00500093) with `mem_ready` held high -> state sequence 0,1,7,8,0; `regwrite`=1 only in cycle 4; `instret`=1.
- `lw` with `mem_ready` delayed 3 cycles in MEMREAD -> MEMREAD held 4 cycles; `mem_req`/`adr_src` stable throughout; total 8 cycles; one `regwrite` with `result_src`=01.
- `bne` with `zero_f`=0 -> `pc_write`=1 in BRANCH; with `zero_f`=1 -> `pc_write`=0; `alu_ctrl`=0001 in both; `blt` gives `alu_ctrl`=0101.
- Opcode 0x7F -> TRAP after DECODE with `trap_cause`=01; strobes stay 0 for 20 cycles; `rst` low then high returns to FETCH.
- `TIMEOUT`=4 with `mem_ready`=0 in FETCH -> TRAP with cause 10 on the 5th cycle; repeat with `mem_ready`=1 in the timeout cycle -> DECODE and no trap.
- `CNT_W`=4 running 17 `addi` instructions -> `instret`=1 after wrap; `rst` asserted mid-MEMWRITE -> `mem_we` drops immediately and `instret`=0.
